program_loader: RTL and testbench

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/program_loader_pkg.sv | 52 +++++
 rtl/program_loader_if.sv | 31 +++
 rtl/loader_clock_posedge.sv | 24 ++
 rtl/program_loader.sv | 89 ++++++++
 tb/tb_program_loader.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/program_loader_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | program_loader_pkg : shared typedefs for the program loader slice    |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
package program_loader_pkg;

    localparam int REGSIZE = 8;

    typedef logic [REGSIZE-1:0] DEFAULT_TYPE;

    typedef enum logic [1:0] {
        MEMORY_STAY  = 2'd0,
        MEMORY_READ  = 2'd1,
        MEMORY_WRITE = 2'd2
    } MEMORY_FLAG_TYPE;

    typedef enum logic [1:0] {
        LOAD_LENGTH     = 2'd0,
        LOAD_DATA       = 2'd1,
        LOAD_WRITE      = 2'd2,
        LOAD_DONE_STATE = 2'd3
    } LOADER_STATE_TYPE;

    typedef struct packed {
        LOADER_STATE_TYPE state;
        DEFAULT_TYPE      length;
        DEFAULT_TYPE      index;
        DEFAULT_TYPE      address;
        DEFAULT_TYPE      write_memory_value;
        MEMORY_FLAG_TYPE  rw_flag;
        DEFAULT_TYPE      checksum;
        logic             cpu_reset;
        logic             load_done;
    } LOADER_REGS_TYPE;

    function automatic LOADER_REGS_TYPE loader_reset_value();
        LOADER_REGS_TYPE v;
        v.state              = LOAD_LENGTH;
        v.length             = '0;
        v.index              = '0;
        v.address            = '0;
        v.write_memory_value = '0;
        v.rw_flag            = MEMORY_STAY;
        v.checksum           = '0;
        v.cpu_reset          = 1'b1;
        v.load_done          = 1'b0;
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/program_loader_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | program_loader_if : byte stream in, memory write bus and status out  |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
interface program_loader_if;
    import program_loader_pkg::*;

    logic            IN_VALID;
    DEFAULT_TYPE     IN_DATA;
    logic            IN_READY;
    DEFAULT_TYPE     address;
    DEFAULT_TYPE     write_memory_value;
    MEMORY_FLAG_TYPE rw_flag;
    logic            CPU_RESET;
    DEFAULT_TYPE     CHECKSUM;
    logic            LOAD_DONE;

    modport master (
        input  IN_VALID, IN_DATA,
        output IN_READY, address, write_memory_value, rw_flag,
               CPU_RESET, CHECKSUM, LOAD_DONE
    );

    modport slave (
        output IN_VALID, IN_DATA,
        input  IN_READY, address, write_memory_value, rw_flag,
               CPU_RESET, CHECKSUM, LOAD_DONE
    );
endinterface
`default_nettype wire

// File: rtl/loader_clock_posedge.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | loader_clock_posedge : the loader's only state, one register bank    |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module loader_clock_posedge
    import program_loader_pkg::*;
(
    input  wire              CLOCK,
    input  wire              RESET,
    input  LOADER_REGS_TYPE  next_regs,
    output LOADER_REGS_TYPE  regs
);

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            regs <= loader_reset_value();
        end else begin
            regs <= next_regs;
        end
    end

endmodule
`default_nettype wire

// File: rtl/program_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | program_loader : streams a length-prefixed image into memory         |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module program_loader
    import program_loader_pkg::*;
(
    input  wire              CLOCK,
    input  wire              RESET,
    program_loader_if.master bus
);

    LOADER_REGS_TYPE r_current;
    LOADER_REGS_TYPE w_next;
    logic            w_in_ready;
    logic            w_handshake;
    DEFAULT_TYPE     w_index_inc;

    assign w_in_ready  = (r_current.state == LOAD_LENGTH) || (r_current.state == LOAD_DATA);
    assign w_handshake = bus.IN_VALID && w_in_ready;
    assign w_index_inc = r_current.index + DEFAULT_TYPE'(1);

    // Every output is a register copy; IN_READY alone is a decode of state.
    always_comb begin
        w_next         = r_current;
        w_next.rw_flag = MEMORY_STAY;
        case (r_current.state)
            LOAD_LENGTH: begin
                if (w_handshake) begin
                    w_next.length = bus.IN_DATA;
                    w_next.index  = '0;
                    if (bus.IN_DATA == '0) begin
                        w_next.state     = LOAD_DONE_STATE;
                        w_next.cpu_reset = 1'b0;
                        w_next.load_done = 1'b1;
                    end else begin
                        w_next.state = LOAD_DATA;
                    end
                end
            end
            LOAD_DATA: begin
                if (w_handshake) begin
                    w_next.address            = r_current.index;
                    w_next.write_memory_value = bus.IN_DATA;
                    w_next.rw_flag            = MEMORY_WRITE;
                    w_next.checksum           = r_current.checksum + bus.IN_DATA;
                    w_next.state              = LOAD_WRITE;
                end
            end
            LOAD_WRITE: begin
                // The write cycle ends here, so releasing CPU_RESET now can
                // never overlap a MEMORY_WRITE.
                w_next.index = w_index_inc;
                if (w_index_inc == r_current.length) begin
                    w_next.state     = LOAD_DONE_STATE;
                    w_next.cpu_reset = 1'b0;
                    w_next.load_done = 1'b1;
                end else begin
                    w_next.state = LOAD_DATA;
                end
            end
            LOAD_DONE_STATE: begin
                w_next.cpu_reset = 1'b0;
                w_next.load_done = 1'b1;
            end
            default: begin
                w_next = loader_reset_value();
            end
        endcase
    end

    loader_clock_posedge u_regs (
        .CLOCK     (CLOCK),
        .RESET     (RESET),
        .next_regs (w_next),
        .regs      (r_current)
    );

    assign bus.IN_READY           = w_in_ready;
    assign bus.address            = r_current.address;
    assign bus.write_memory_value = r_current.write_memory_value;
    assign bus.rw_flag            = r_current.rw_flag;
    assign bus.CPU_RESET          = r_current.cpu_reset;
    assign bus.CHECKSUM           = r_current.checksum;
    assign bus.LOAD_DONE          = r_current.load_done;

endmodule
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_program_loader : random length-prefixed loads vs. a write model   |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_program_loader;
    import program_loader_pkg::*;

    logic CLOCK = 1'b0;
    logic RESET = 1'b1;

    program_loader_if bus();

    program_loader dut (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .bus   (bus.master)
    );

    always #5 CLOCK = ~CLOCK;

    int n_vectors     = 0;
    int n_miscompares = 0;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_vectors++;
        if (actual !== expected) begin
            n_miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t  wr_q[$];
    logic prev_write = 1'b0;

    // Observed memory writes, plus per-write-cycle properties.
    always @(negedge CLOCK) begin
        if (RESET) begin
            prev_write = 1'b0;
        end else if (bus.rw_flag == MEMORY_WRITE) begin
            wr_q.push_back('{bus.address, bus.write_memory_value});
            check("write_single_cycle", 32'(prev_write), 32'd0);
            check("cpu_reset_during_write", 32'(bus.CPU_RESET), 32'd1);
            check("ready_low_in_write", 32'(bus.IN_READY), 32'd0);
            prev_write = 1'b1;
        end else begin
            prev_write = 1'b0;
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        logic acc;
        repeat (gap) begin
            @(negedge CLOCK);
            bus.IN_VALID = 1'b0;
            bus.IN_DATA  = 8'($urandom);
            @(posedge CLOCK);
        end
        @(negedge CLOCK);
        bus.IN_VALID = 1'b1;
        bus.IN_DATA  = b;
        for (int k = 0; k < 64; k++) begin
            acc = bus.IN_READY;
            @(posedge CLOCK);
            if (acc) return;
            @(negedge CLOCK);
        end
        check("handshake_timeout", 32'd0, 32'd1);
    endtask

    task automatic reset_dut();
        @(negedge CLOCK);
        #1 RESET = 1'b1;
        bus.IN_VALID = 1'b0;
        @(posedge CLOCK);
        @(negedge CLOCK);
        check("rst_address", 32'(bus.address), 32'd0);
        check("rst_wdata", 32'(bus.write_memory_value), 32'd0);
        check("rst_rw_flag", 32'(bus.rw_flag), 32'(MEMORY_STAY));
        check("rst_checksum", 32'(bus.CHECKSUM), 32'd0);
        check("rst_cpu_reset", 32'(bus.CPU_RESET), 32'd1);
        check("rst_load_done", 32'(bus.LOAD_DONE), 32'd0);
        check("rst_in_ready", 32'(bus.IN_READY), 32'd1);
        #1 RESET = 1'b0;
        wr_q.delete();
    endtask

    // gap < 0 selects a random idle gap of 0..3 cycles before each data byte.
    task automatic do_load(input int len, input logic [7:0] bytes[$], input int gap);
        int sum;
        int k;
        sum = 0;
        wr_q.delete();
        send_byte(8'(len), 0);
        foreach (bytes[i]) begin
            send_byte(bytes[i], (gap < 0) ? int'($urandom_range(0, 3)) : gap);
            sum = (sum + int'(bytes[i])) % 256;
        end
        @(negedge CLOCK);
        bus.IN_VALID = 1'b0;
        for (k = 0; k < 8; k++) begin
            if (bus.LOAD_DONE) break;
            @(negedge CLOCK);
        end
        check("done_latency", 32'(k), (len == 0) ? 32'd0 : 32'd1);
        check("load_done", 32'(bus.LOAD_DONE), 32'd1);
        check("cpu_reset_released", 32'(bus.CPU_RESET), 32'd0);
        check("done_rw_flag", 32'(bus.rw_flag), 32'(MEMORY_STAY));
        check("done_in_ready", 32'(bus.IN_READY), 32'd0);
        check("checksum", 32'(bus.CHECKSUM), 32'(sum));
        check("write_count", 32'(wr_q.size()), 32'(len));
        for (int i = 0; i < wr_q.size() && i < len; i++) begin
            check("wr_addr", 32'(wr_q[i].addr), 32'(i));
            check("wr_data", 32'(wr_q[i].data), 32'(bytes[i]));
        end
        // Junk while done must neither be consumed nor written.
        bus.IN_VALID = 1'b1;
        repeat (3) @(negedge CLOCK);
        bus.IN_VALID = 1'b0;
        check("done_held", 32'(bus.LOAD_DONE), 32'd1);
        check("no_late_writes", 32'(wr_q.size()), 32'(len));
    endtask

    initial begin
        logic [7:0] q[$];
        int         len;

        bus.IN_VALID = 1'b0;
        bus.IN_DATA  = '0;
        repeat (2) @(posedge CLOCK);
        reset_dut();

        q = {8'h13, 8'h0F, 8'hF0};
        do_load(3, q, 0);
        reset_dut();

        q = {};
        do_load(0, q, 0);
        reset_dut();

        q = {8'($urandom), 8'($urandom)};
        do_load(2, q, 5);
        reset_dut();

        for (int t = 0; t < 6; t++) begin
            len = int'($urandom_range(1, 20));
            q = {};
            for (int i = 0; i < len; i++) q.push_back(8'($urandom));
            do_load(len, q, -1);
            reset_dut();
        end

        // Abort after the first of four bytes; the next byte is a new length.
        send_byte(8'd4, 0);
        send_byte(8'($urandom), 0);
        reset_dut();
        repeat (5) @(negedge CLOCK);
        check("abort_no_writes", 32'(wr_q.size()), 32'd0);
        q = {8'($urandom), 8'($urandom)};
        do_load(2, q, 0);
        reset_dut();

        q = {};
        for (int i = 0; i < 255; i++) q.push_back(8'hFF);
        do_load(255, q, 0);
        if (wr_q.size() == 255) check("last_addr", 32'(wr_q[254].addr), 32'hFE);
        else check("last_addr_missing", 32'(wr_q.size()), 32'd255);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
`default_nettype wire
